// File: rtl/out_port_alloc_3op_pkg.sv
// Shared router definitions for the output-port allocator: source indices,
// allocator state encoding and default flit width.
package out_port_alloc_3op_pkg;

    localparam int PORTS_N        = 3;
    localparam int SRC_LOCAL      = 0;
    localparam int SRC_FSM1       = 1;
    localparam int SRC_FSM2       = 2;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic {
        ALLOC_IDLE = 1'b0,
        ALLOC_BUSY = 1'b1
    } alloc_state_t;

endpackage

// File: rtl/out_port_alloc_3op_if.sv
// Allocator bus: source flit inputs, priority-selector loop, output link and status.
// Handshake: a flit moves on a link only in a cycle where valid and ready are both high;
// valid never depends on ready, and data/tail are meaningful only while valid is high.
interface out_port_alloc_3op_if
    import out_port_alloc_3op_pkg::*;
#(
    parameter int PORTS  = PORTS_N,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = 16
);

    logic [PORTS-1:0]        req_i;
    logic [PORTS-1:0]        valid_i;
    logic [PORTS-1:0]        tail_i;
    logic [PORTS*DATA_W-1:0] data_i;
    logic [PORTS-1:0]        ready_o;

    logic [PORTS-1:0]        prio_req_o;
    logic [PORTS-1:0]        prio_sel_i;

    logic                    out_valid_o;
    logic [DATA_W-1:0]       out_data_o;
    logic                    out_tail_o;
    logic                    out_ready_i;

    logic [PORTS-1:0]        grant_o;
    logic                    busy_o;
    logic                    timeout_o;
    logic [CNT_W-1:0]        pkt_cnt_o;
    alloc_state_t            state_dbg;

    modport slave (
        input  req_i, valid_i, tail_i, data_i, prio_sel_i, out_ready_i,
        output ready_o, prio_req_o, out_valid_o, out_data_o, out_tail_o,
        output grant_o, busy_o, timeout_o, pkt_cnt_o, state_dbg
    );

    modport master (
        output req_i, valid_i, tail_i, data_i, prio_sel_i, out_ready_i,
        input  ready_o, prio_req_o, out_valid_o, out_data_o, out_tail_o,
        input  grant_o, busy_o, timeout_o, pkt_cnt_o, state_dbg
    );

endinterface

// File: rtl/out_port_alloc_3op_onehot_mux.sv
// AND-OR flit selector: picks the DATA_W slice of data whose sel bit is set.
// An all-zero sel yields zero.
module onehot_mux #(
    parameter int PORTS  = 3,
    parameter int DATA_W = 32
) (
    input  logic [PORTS-1:0]        sel,
    input  logic [PORTS*DATA_W-1:0] data,
    output logic [DATA_W-1:0]       y
);

    always_comb begin
        y = '0;
        for (int k = 0; k < PORTS; k++) begin
            y = y | (data[k*DATA_W +: DATA_W] & {DATA_W{sel[k]}});
        end
    end

endmodule

// File: rtl/out_port_alloc_3op.sv
// Output-port allocator: forwards requests to the external priority selector,
// holds the granted circuit until tail accept or idle timeout, and muxes its flits out.
module out_port_alloc_3op
    import out_port_alloc_3op_pkg::*;
#(
    parameter int PORTS   = PORTS_N,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    out_port_alloc_3op_if.slave bus
);

    localparam int                IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    alloc_state_t      state_q, state_d;
    logic [PORTS-1:0]  grant_q, grant_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;

    logic              busy;
    logic [PORTS-1:0]  sel_low;
    logic [PORTS-1:0]  live_grant;
    logic              g_valid;
    logic              g_tail;
    logic              accept;
    logic              tail_accept;

    assign busy       = (state_q == ALLOC_BUSY);
    // Lowest set bit only, so an illegal multi-hot selector output still yields a one-hot grant.
    assign sel_low    = bus.prio_sel_i & (~bus.prio_sel_i + PORTS'(1));
    assign live_grant = grant_q & {PORTS{busy}};

    assign g_valid     = |(bus.valid_i & live_grant);
    assign g_tail      = |(bus.tail_i & bus.valid_i & live_grant);
    assign accept      = g_valid & bus.out_ready_i;
    assign tail_accept = accept & g_tail;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ALLOC_IDLE;
            grant_q   <= '0;
            idle_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idle_q    <= idle_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idle_d    = idle_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ALLOC_IDLE: begin
                idle_d = '0;
                if (|bus.prio_sel_i) begin
                    grant_d = sel_low;
                    state_d = ALLOC_BUSY;
                end
            end
            ALLOC_BUSY: begin
                if (tail_accept) begin
                    grant_d = '0;
                    idle_d  = '0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ALLOC_IDLE;
                end else if (accept) begin
                    idle_d = '0;
                end else if (!g_valid) begin
                    // Stalled source: count silence; a valid-but-blocked flit holds the count.
                    if (idle_q == IDLE_LAST) begin
                        grant_d   = '0;
                        idle_d    = '0;
                        timeout_d = 1'b1;
                        state_d   = ALLOC_IDLE;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
            end
            default: begin
                grant_d = '0;
                idle_d  = '0;
                state_d = ALLOC_IDLE;
            end
        endcase
    end

    onehot_mux #(
        .PORTS  (PORTS),
        .DATA_W (DATA_W)
    ) u_data_mux (
        .sel  (live_grant),
        .data (bus.data_i),
        .y    (bus.out_data_o)
    );

    assign bus.prio_req_o  = busy ? '0 : bus.req_i;
    assign bus.out_valid_o = g_valid;
    assign bus.out_tail_o  = g_tail;
    assign bus.ready_o     = live_grant & {PORTS{bus.out_ready_i}};

    assign bus.grant_o   = grant_q;
    assign bus.busy_o    = busy;
    assign bus.timeout_o = timeout_q;
    assign bus.pkt_cnt_o = cnt_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_out_port_alloc_3op.sv
// Bench for out_port_alloc_3op: directed scenarios plus random traffic, every cycle
// compared against a circuit-ownership model of the allocator.
module tb_out_port_alloc_3op;

    localparam int PORTS   = 3;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    out_port_alloc_3op_if #(.PORTS(PORTS), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    out_port_alloc_3op #(
        .PORTS   (PORTS),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic       sel_force_en = 1'b0;
    logic [2:0] sel_force    = 3'b000;

    // Fixed-priority selector in the loop (LOCAL > FSM1 > FSM2), with an override for illegal patterns.
    always_comb begin
        bus.prio_sel_i = '0;
        if (sel_force_en)              bus.prio_sel_i = sel_force;
        else if (bus.prio_req_o[0])    bus.prio_sel_i = 3'b001;
        else if (bus.prio_req_o[1])    bus.prio_sel_i = 3'b010;
        else if (bus.prio_req_o[2])    bus.prio_sel_i = 3'b100;
    end

    // Reference model: who owns the circuit, how long it has been silent, packets done.
    int owner;
    int silent;
    int pkts;
    bit to_flag;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner   = -1;
        silent  = 0;
        pkts    = 0;
        to_flag = 0;
    endtask

    task automatic model_check();
        logic [2:0]        g_e, rdy_e, pr_e;
        logic              ov_e, ot_e;
        logic [DATA_W-1:0] od_e;
        g_e = '0; rdy_e = '0; ov_e = 1'b0; ot_e = 1'b0; od_e = '0;
        pr_e = bus.req_i;
        if (owner >= 0) begin
            g_e[owner] = 1'b1;
            pr_e = '0;
            ov_e = bus.valid_i[owner];
            ot_e = ov_e & bus.tail_i[owner];
            od_e = bus.data_i[owner*DATA_W +: DATA_W];
            if (bus.out_ready_i) rdy_e[owner] = 1'b1;
        end
        check_eq("grant",     bus.grant_o,     g_e);
        check_eq("busy",      bus.busy_o,      owner >= 0);
        check_eq("state",     bus.state_dbg,   owner >= 0);
        check_eq("prio_req",  bus.prio_req_o,  pr_e);
        check_eq("out_valid", bus.out_valid_o, ov_e);
        check_eq("out_tail",  bus.out_tail_o,  ot_e);
        check_eq("out_data",  bus.out_data_o,  od_e);
        check_eq("ready",     bus.ready_o,     rdy_e);
        check_eq("timeout",   bus.timeout_o,   to_flag);
        check_eq("pkt_cnt",   bus.pkt_cnt_o,   pkts);
    endtask

    task automatic model_step();
        logic [2:0] s;
        logic       acc;
        to_flag = 0;
        if (owner < 0) begin
            silent = 0;
            s = sel_force_en ? sel_force : bus.req_i;
            for (int k = 2; k >= 0; k--) if (s[k]) owner = k;
        end else begin
            acc = bus.valid_i[owner] & bus.out_ready_i;
            if (acc && bus.tail_i[owner]) begin
                owner  = -1;
                silent = 0;
                pkts   = (pkts + 1) % (1 << CNT_W);
            end else if (acc) begin
                silent = 0;
            end else if (!bus.valid_i[owner]) begin
                silent++;
                if (silent == TIMEOUT) begin
                    owner   = -1;
                    silent  = 0;
                    to_flag = 1;
                end
            end
        end
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] v, input logic [2:0] t,
                         input logic ordy);
        bus.req_i       = r;
        bus.valid_i     = v;
        bus.tail_i      = t;
        bus.out_ready_i = ordy;
        bus.data_i      = {$urandom, $urandom, $urandom};
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic tick();
        #1;
        model_check();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         pk0;
        logic       prev_busy;
        logic [2:0] r, v, t;

        drive(3'b000, 3'b000, 3'b000, 1'b0);
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_grant", bus.grant_o, 3'b000);
        check_eq("rst_busy", bus.busy_o, 1'b0);
        check_eq("rst_timeout", bus.timeout_o, 1'b0);
        check_eq("rst_pkt", bus.pkt_cnt_o, 0);
        rst_n = 1'b1;

        // Simultaneous FSM1+FSM2 requests: FSM1 wins, 3-flit packet, then FSM2 after one dead cycle.
        drive(3'b110, 3'b000, 3'b000, 1'b1); tick();
        check_eq("sim_c1_grant", bus.grant_o, 3'b010);
        check_eq("sim_c1_prio_req", bus.prio_req_o, 3'b000);
        drive(3'b110, 3'b010, 3'b000, 1'b1); tick();
        drive(3'b110, 3'b010, 3'b000, 1'b1); tick();
        drive(3'b110, 3'b010, 3'b010, 1'b1); tick();
        check_eq("sim_c4_busy", bus.busy_o, 1'b0);
        check_eq("sim_c4_pkt", bus.pkt_cnt_o, 1);
        drive(3'b100, 3'b000, 3'b000, 1'b1); tick();
        check_eq("sim_c5_grant", bus.grant_o, 3'b100);
        drive(3'b000, 3'b100, 3'b100, 1'b1); tick();
        drive(3'b000, 3'b000, 3'b000, 1'b1); tick();

        // Backpressure on LOCAL never times out.
        drive(3'b001, 3'b000, 3'b000, 1'b0); tick();
        check_eq("bp_grant", bus.grant_o, 3'b001);
        drive(3'b001, 3'b001, 3'b000, 1'b0);
        for (int i = 0; i < 40; i++) begin
            tick();
            check_eq("bp_ready", bus.ready_o, 3'b000);
            check_eq("bp_no_timeout", bus.timeout_o, 1'b0);
        end
        check_eq("bp_hold", bus.grant_o, 3'b001);
        pk0 = pkts;
        drive(3'b000, 3'b001, 3'b001, 1'b1); tick();
        check_eq("bp_release", bus.busy_o, 1'b0);
        check_eq("bp_pkt", bus.pkt_cnt_o, (pk0 + 1) % (1 << CNT_W));

        // Idle FSM1 is released after TIMEOUT silent cycles.
        drive(3'b010, 3'b000, 3'b000, 1'b1); tick();
        check_eq("to_grant", bus.grant_o, 3'b010);
        pk0 = pkts;
        drive(3'b000, 3'b000, 3'b000, 1'b1);
        repeat (TIMEOUT - 1) tick();
        check_eq("to_still_busy", bus.busy_o, 1'b1);
        check_eq("to_not_yet", bus.timeout_o, 1'b0);
        tick();
        check_eq("to_grant_clr", bus.grant_o, 3'b000);
        check_eq("to_pulse", bus.timeout_o, 1'b1);
        check_eq("to_pkt_same", bus.pkt_cnt_o, pk0);
        tick();
        check_eq("to_pulse_end", bus.timeout_o, 1'b0);

        // Illegal multi-hot selector output latches only its lowest bit.
        sel_force_en = 1'b1; sel_force = 3'b110;
        drive(3'b000, 3'b000, 3'b000, 1'b1); tick();
        sel_force_en = 1'b0;
        check_eq("mh_grant", bus.grant_o, 3'b010);
        drive(3'b000, 3'b010, 3'b010, 1'b1); tick();
        drive(3'b000, 3'b000, 3'b000, 1'b1); tick();

        // Back-to-back single-flit LOCAL packets: BUSY/IDLE alternate, counter wraps.
        pk0 = pkts;
        prev_busy = bus.busy_o;
        drive(3'b001, 3'b001, 3'b001, 1'b1);
        for (int i = 0; i < 600; i++) begin
            tick();
            check_eq("sf_toggle", bus.busy_o, !prev_busy);
            prev_busy = bus.busy_o;
        end
        check_eq("sf_pkt_wrap", bus.pkt_cnt_o, (pk0 + 300) % (1 << CNT_W));
        drive(3'b000, 3'b000, 3'b000, 1'b1); tick();

        // Reset in the middle of an FSM2 packet drops the circuit at once.
        drive(3'b100, 3'b000, 3'b000, 1'b1); tick();
        drive(3'b100, 3'b100, 3'b000, 1'b1); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check_eq("mrst_grant", bus.grant_o, 3'b000);
        check_eq("mrst_busy", bus.busy_o, 1'b0);
        check_eq("mrst_out_valid", bus.out_valid_o, 1'b0);
        check_eq("mrst_pkt", bus.pkt_cnt_o, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic, with periodic silent windows so timeouts also occur.
        for (int i = 0; i < 3000; i++) begin
            r = 3'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++) begin
                v[k] = ($urandom_range(0, 3) != 0);
                t[k] = ($urandom_range(0, 3) == 0);
            end
            if ((i % 500) >= 460) v = 3'b000;
            sel_force_en = ($urandom_range(0, 19) == 0);
            sel_force    = 3'($urandom_range(1, 7));
            drive(r, v, t, ($urandom_range(0, 3) != 0));
            tick();
        end
        sel_force_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
